// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data-access paths.
// Each transaction goes through arbitration (IDLE), the memory access (ACCESS) and a one-cycle acknowledge (ACK).
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              iacq,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              dacq,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        state_dbg
);

  // Handshake: i_req and d_rd/d_wr are levels, held until iacq/dacq is seen high
  // for one cycle. The requester must drop or change its request on that same edge.
  // Requests are sampled only in IDLE.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state;
  logic               last_grant_data;
  logic               owner_data;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               d_req;
  logic               grant_data;
  logic               tmo_hit;

  assign d_req = d_rd | d_wr;
  // Data wins when it is the only requester, or when both request and the fetch side was served last.
  assign grant_data = d_req && (!i_req || !last_grant_data);
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_grant_data <= 1'b0;
      owner_data      <= 1'b0;
      tmo_cnt         <= '0;
      iacq            <= 1'b0;
      dacq            <= 1'b0;
      err             <= 1'b0;
      busy            <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      i_data          <= '0;
      d_rdata         <= '0;
    end else begin
      case (state)
        IDLE: begin
          iacq <= 1'b0;
          dacq <= 1'b0;
          err  <= 1'b0;
          if (i_req || d_req) begin
            state           <= ACCESS;
            busy            <= 1'b1;
            mem_en          <= 1'b1;
            owner_data      <= grant_data;
            last_grant_data <= grant_data;
            tmo_cnt         <= '0;
            if (grant_data) begin
              mem_addr  <= d_addr;
              mem_we    <= d_wr;
              mem_wdata <= d_wr ? d_wdata : '0;
            end else begin
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end

        ACCESS: begin
          if (mem_ready || tmo_hit) begin
            state  <= ACK;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            iacq   <= !owner_data;
            dacq   <= owner_data;
            err    <= !mem_ready;
            // Only a successful read updates the read registers; writes and timeouts leave them alone.
            if (mem_ready) begin
              if (!owner_data) begin
                i_data <= mem_rdata;
              end else if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ACK: begin
          state   <= IDLE;
          iacq    <= 1'b0;
          dacq    <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          tmo_cnt <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, arbitration order, write with wait states,
// timeout, reset during an access and a simultaneous read+write request.
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data;
  logic              iacq;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              dacq;
  logic              err;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic both_acks_seen = 1'b0;
  int en_cycles;

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .iacq     (iacq),
    .d_rd     (d_rd),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .dacq     (dacq),
    .err      (err),
    .busy     (busy),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iacq && dacq) both_acks_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before looking at registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    tick();
    tick();

    check("rst_state", state_dbg, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_acks", {iacq, dacq, err}, 0);
    check("rst_i_data", i_data, 0);
    check("rst_d_rdata", d_rdata, 0);

    // 1: single fetch, memory ready on the first ACCESS cycle
    rst       = 1'b0;
    i_req     = 1'b1;
    i_addr    = 16'h0010;
    mem_ready = 1'b1;
    mem_rdata = 8'd80;
    tick();
    check("t1_state_access", state_dbg, S_ACCESS);
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 16'h0010);
    check("t1_mem_we", mem_we, 0);
    check("t1_busy", busy, 1);
    check("t1_no_ack_yet", iacq, 0);
    tick();
    check("t1_iacq", iacq, 1);
    check("t1_dacq", dacq, 0);
    check("t1_i_data", i_data, 8'd80);
    check("t1_mem_en_off", mem_en, 0);
    check("t1_busy_ack", busy, 1);
    i_req     = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("t1_iacq_pulse", iacq, 0);
    check("t1_idle", state_dbg, S_IDLE);
    check("t1_busy_off", busy, 0);

    // 2: both requesting right after a fetch grant -> data first, then contention again -> fetch
    i_req     = 1'b1;
    i_addr    = 16'h0020;
    d_rd      = 1'b1;
    d_addr    = 16'h0100;
    mem_ready = 1'b1;
    mem_rdata = 8'h33;
    tick();
    check("t2_first_data_addr", mem_addr, 16'h0100);
    tick();
    check("t2_dacq1", dacq, 1);
    check("t2_no_iacq1", iacq, 0);
    check("t2_d_rdata1", d_rdata, 8'h33);
    d_rd      = 1'b0;
    mem_rdata = 8'h44;
    tick();
    check("t2_gap_idle", state_dbg, S_IDLE);
    d_rd   = 1'b1;
    d_addr = 16'h0101;
    tick();
    check("t2_rr_fetch_addr", mem_addr, 16'h0020);
    tick();
    check("t2_iacq", iacq, 1);
    check("t2_i_data", i_data, 8'h44);
    i_req     = 1'b0;
    mem_rdata = 8'h55;
    tick();
    tick();
    check("t2_data_addr2", mem_addr, 16'h0101);
    tick();
    check("t2_dacq2", dacq, 1);
    check("t2_d_rdata2", d_rdata, 8'h55);
    d_rd      = 1'b0;
    mem_ready = 1'b0;
    tick();

    // 3: write with three wait cycles
    d_wr      = 1'b1;
    d_addr    = 16'h0200;
    d_wdata   = 8'hA5;
    mem_rdata = 8'hEE;
    tick();
    check("t3_mem_we", mem_we, 1);
    check("t3_mem_wdata", mem_wdata, 8'hA5);
    check("t3_mem_addr", mem_addr, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_en_we", {mem_en, mem_we}, 2'b11);
    end
    mem_ready = 1'b1;
    tick();
    check("t3_dacq", dacq, 1);
    check("t3_en_we_off", {mem_en, mem_we}, 2'b00);
    check("t3_d_rdata_kept", d_rdata, 8'h55);
    check("t3_no_err", err, 0);
    d_wr      = 1'b0;
    mem_ready = 1'b0;
    tick();

    // 4: read that never completes -> timeout
    d_rd   = 1'b1;
    d_addr = 16'h0300;
    tick();
    en_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (dacq) break;
      if (mem_en) en_cycles++;
      tick();
    end
    check("t4_en_cycles", en_cycles, TIMEOUT);
    check("t4_dacq", dacq, 1);
    check("t4_err", err, 1);
    check("t4_d_rdata_kept", d_rdata, 8'h55);
    d_rd = 1'b0;
    tick();
    check("t4_busy_off", busy, 0);
    check("t4_err_pulse", {err, dacq}, 0);

    // 5: reset during a fetch access
    i_req     = 1'b1;
    i_addr    = 16'h0400;
    mem_rdata = 8'h77;
    tick();
    check("t5_access", mem_en, 1);
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_mem_en", mem_en, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_i_data", i_data, 0);
    check("t5_rst_no_iacq", iacq, 0);
    check("t5_rst_d_rdata", d_rdata, 0);
    rst       = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("t5_regrant_addr", mem_addr, 16'h0400);
    tick();
    check("t5_iacq", iacq, 1);
    check("t5_i_data", i_data, 8'h77);
    i_req     = 1'b0;
    mem_ready = 1'b0;
    tick();

    // 6: read and write together is a write
    d_rd      = 1'b1;
    d_wr      = 1'b1;
    d_addr    = 16'h0500;
    d_wdata   = 8'h3C;
    mem_ready = 1'b1;
    mem_rdata = 8'h99;
    tick();
    check("t6_mem_we", mem_we, 1);
    check("t6_mem_wdata", mem_wdata, 8'h3C);
    tick();
    check("t6_dacq", dacq, 1);
    check("t6_d_rdata_kept", d_rdata, 0);
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("t6_dacq_pulse", dacq, 0);
    tick();
    check("t6_stays_idle", state_dbg, S_IDLE);

    check("ack_mutex", both_acks_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between the Control_Unit's instruction-fetch path and its data-access path.
- Sequences each memory transaction: arbitration, then access, then completion.
- Returns the iacq/dacq acknowledge pulses that the Control_Unit uses to leave its fetch and memory wait states.
- Sits between Control_Unit/datapath and the shared RAM, and tolerates variable memory latency with a timeout.

Parameters:
ADDR_W, 16, address width of both requesters and memory
DATA_W, 8, data/instruction word width
TIMEOUT, 15, max cycles in ACCESS waiting for mem_ready; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  instruction fetch request, level, held until iacq
i_addr  in  ADDR_W  fetch address (PC)
i_data  out  DATA_W  fetched instruction, registered
iacq  out  1  fetch complete, 1-cycle pulse
d_rd  in  1  data read request, level, held until dacq
d_wr  in  1  data write request, level, held until dacq
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, registered
dacq  out  1  data access complete, 1-cycle pulse
err  out  1  timeout abort, 1-cycle pulse coincident with iacq/dacq
busy  out  1  high whenever state != IDLE
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completion, sampled only in ACCESS

Behaviour:
- Clock is clk; reset is synchronous, active-high, on port rst.
- Reset on the rst edge, including mid-transaction: state=IDLE; iacq, dacq, err, busy, mem_en, mem_we = 0; mem_addr, mem_wdata, i_data, d_rdata = 0; timeout counter=0; last_grant=INSTR. An in-flight access is abandoned and no ack is issued.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - One requester active: grant it.
  - Both i_req and (d_rd|d_wr) active: round-robin. Grant the side opposite last_grant.
  - Update last_grant on each grant. Go to ACCESS.
  - Latch into owner/op registers at the grant edge: mem_addr, mem_we (1 only for a data write), mem_wdata (d_wdata for a write, else 0).
- d_rd and d_wr both high: treated as a write.
- ACCESS:
  - mem_en=1; mem_addr, mem_we, mem_wdata held stable.
  - On an edge with mem_ready=1: capture mem_rdata into i_data (fetch) or d_rdata (data read). A write leaves d_rdata unchanged. Go to ACK.
  - Timeout counter increments each ACCESS cycle without mem_ready. TIMEOUT!=0 and count reaches TIMEOUT: go to ACK with err flag set; read registers unchanged.
- ACK:
  - Assert exactly one cycle: iacq (fetch owner) or dacq (data owner), plus err if timed out.
  - mem_en=0, mem_we=0. Clear counter and err flag. Go to IDLE unconditionally.
- Requesters must drop or change their request on the edge where they sample ack=1. The IDLE cycle after ACK is mandatory, so back-to-back grants are at least 3 cycles apart.
- Minimum latency: request high at edge N (IDLE) → ACCESS from N, mem_ready=1 at edge N+1 → ack high during cycle after N+1 → IDLE after N+2.
- Requests arriving or dropping outside IDLE are ignored until IDLE. A request dropped before grant is not served.
- busy is 1 during ACCESS and ACK.
- iacq and dacq are never high in the same cycle.

Test Plan:
1. Single fetch, rst released, i_req=1, i_addr=16'h0010, mem_ready=1 on first ACCESS cycle, mem_rdata=8'd80 → mem_en for 1 cycle with mem_addr=16'h0010, iacq 1-cycle pulse 2 cycles after grant, i_data=80, dacq=0.
2. Simultaneous i_req and d_rd after reset, d_addr=16'h0100 → data served first (last_grant=INSTR), then fetch. Second round of simultaneous requests → fetch served first.
3. Data write, d_wr=1, d_addr=16'h0200, d_wdata=8'hA5, mem_ready after 3 wait cycles → mem_en=1, mem_we=1 held 4 cycles, dacq pulse, d_rdata unchanged from previous value.
4. Timeout, d_rd=1, mem_ready never asserted, TIMEOUT=15 → mem_en high 15 cycles, then dacq=1 and err=1 together for one cycle, d_rdata unchanged, busy falls next cycle.
5. Reset mid-access: rst=1 during ACCESS of a fetch → next edge mem_en=0, busy=0, i_data=0, no iacq. A new i_req after rst deassert completes normally.
6. d_rd=1 and d_wr=1 together → write performed (mem_we=1), single dacq pulse.
